gaussian_window_ctrl: RTL and testbench

//  Frame sequencer feeding the 3x3 Gaussian filter. Accepts a raster-order 8-bit pixel stream,

---
 rtl/gaussian_window_ctrl.sv | 116 +++++++++++
 tb/tb_gaussian_window_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_window_ctrl.sv
// Raster pixel stream to 3x3 window sequencer for the Gaussian filter; two line buffers hold rows r-1, r-2.
// Windows are registered: window_valid pulses one cycle after the accepting edge, interior pixels only.
module gaussian_window_ctrl #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int CNT_W = 10
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_in_valid,
    output logic        pix_in_ready,
    output logic [71:0] window_out,
    output logic        window_valid,
    output logic        busy,
    output logic        frame_done
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_row;
    logic [CNT_W-1:0]   r_col;
    logic [71:0]        r_win;
    logic               r_win_vld;
    logic               r_done;
    logic [7:0]         r_lb0 [IMG_W];
    logic [7:0]         r_lb1 [IMG_W];

    logic               w_accept;
    logic               w_last_col;
    logic               w_last_row;
    logic [AW-1:0]      w_idx;
    logic [7:0]         w_top;
    logic [7:0]         w_mid;

    assign pix_in_ready = (r_state == S_FILL) || (r_state == S_RUN);
    assign busy         = pix_in_ready;
    assign w_accept     = pix_in_valid & pix_in_ready;
    assign w_last_col   = (r_col == CNT_W'(IMG_W - 1));
    assign w_last_row   = (r_row == CNT_W'(IMG_H - 1));
    assign w_idx        = r_col[AW-1:0];
    assign w_top        = r_lb1[w_idx];
    assign w_mid        = r_lb0[w_idx];

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_FILL;
            S_FILL: if (w_accept && w_last_col && (r_row == CNT_W'(1))) w_next = S_RUN;
            S_RUN:  if (w_accept && w_last_col && w_last_row) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_row <= '0;
            r_col <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + CNT_W'(1);
            end else begin
                r_col <= r_col + CNT_W'(1);
            end
        end
    end

    // Line buffers are plain RAM: never reset, every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[w_idx] <= r_lb0[w_idx];
            r_lb0[w_idx] <= pix_in;
        end
    end

    // Shift one column left; new right column is {top, mid, pix} in bytes 2, 5, 8.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_win     <= '0;
            r_win_vld <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_win_vld <= w_accept && (r_row >= CNT_W'(2)) && (r_col >= CNT_W'(2));
            r_done    <= w_accept && (r_state == S_RUN) && w_last_row && w_last_col;
            if (w_accept) begin
                r_win <= {pix_in, r_win[71:56], w_mid, r_win[47:32], w_top, r_win[23:8]};
            end
        end
    end

    assign window_out   = r_win;
    assign window_valid = r_win_vld;
    assign frame_done   = r_done;

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Directed bench: 5x4 instance for frame/gap/start/reset/back-to-back cases, 3x3 instance for the minimum frame.
module tb_gaussian_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        a_start, a_valid, b_start, b_valid;
    logic [7:0]  a_pix, b_pix;
    logic        a_ready, a_wv, a_busy, a_fd;
    logic        b_ready, b_wv, b_busy, b_fd;
    logic [71:0] a_win, b_win;

    gaussian_window_ctrl #(.IMG_W(5), .IMG_H(4), .CNT_W(10)) dut_a (
        .clk(clk), .rstN(rstN), .start(a_start), .pix_in(a_pix), .pix_in_valid(a_valid),
        .pix_in_ready(a_ready), .window_out(a_win), .window_valid(a_wv), .busy(a_busy),
        .frame_done(a_fd)
    );

    gaussian_window_ctrl #(.IMG_W(3), .IMG_H(3), .CNT_W(10)) dut_b (
        .clk(clk), .rstN(rstN), .start(b_start), .pix_in(b_pix), .pix_in_valid(b_valid),
        .pix_in_ready(b_ready), .window_out(b_win), .window_valid(b_wv), .busy(b_busy),
        .frame_done(b_fd)
    );

    int checks = 0;
    int failures = 0;
    logic [71:0] a_q[$];
    logic [71:0] b_q[$];
    int a_fd_cnt = 0;
    int b_fd_cnt = 0;
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: a window may only follow an accept, and frame_done must coincide with a window.
    always @(negedge clk) begin
        if (a_wv) begin
            a_q.push_back(a_win);
            check("a_wv_after_accept", 72'(a_prev), 72'd1);
        end
        if (a_fd) begin
            a_fd_cnt++;
            check("a_fd_with_wv", 72'(a_wv), 72'd1);
        end
        a_prev = a_valid & a_ready;
        if (b_wv) begin
            b_q.push_back(b_win);
            check("b_wv_after_accept", 72'(b_prev), 72'd1);
        end
        if (b_fd) begin
            b_fd_cnt++;
            check("b_fd_with_wv", 72'(b_wv), 72'd1);
        end
        b_prev = b_valid & b_ready;
    end

    function automatic logic [71:0] exp_win(input int w, input int base, input int r, input int c);
        logic [71:0] res;
        int v;
        res = '0;
        for (int i = 0; i < 9; i++) begin
            v = base + (r - 2 + i / 3) * w + (c - 2 + i % 3);
            res[i*8 +: 8] = v[7:0];
        end
        return res;
    endfunction

    task automatic set_in(input bit sel, input logic vld, input logic [7:0] px, input logic st);
        if (sel) begin
            b_valid = vld; b_pix = px; b_start = st;
        end else begin
            a_valid = vld; a_pix = px; a_start = st;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit sel);
        set_in(sel, 1'b0, 8'd0, 1'b1);
        tick();
        set_in(sel, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic feed(input bit sel, input int base, input bit gap, input int npix,
                        input int start_at, input bit b2b);
        int px;
        for (int i = 0; i < npix; i++) begin
            if (gap && (i % 2 == 1)) begin
                set_in(sel, 1'b0, 8'd0, 1'b0);
                tick();
            end
            px = base + i;
            set_in(sel, 1'b1, px[7:0], (i == start_at));
            check("ready_in_frame", 72'(sel ? b_ready : a_ready), 72'd1);
            tick();
        end
        set_in(sel, 1'b0, 8'd0, b2b);
        if (b2b) begin
            tick();
            set_in(sel, 1'b0, 8'd0, 1'b0);
        end
    endtask

    task automatic verify(input bit sel, input int w, input int h, input int base, input int off);
        int k;
        logic [71:0] got;
        k = off;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                if (k < (sel ? b_q.size() : a_q.size())) begin
                    got = sel ? b_q[k] : a_q[k];
                    check($sformatf("win%0d_base%0d_r%0d_c%0d", sel, base, r, c), got,
                          exp_win(w, base, r, c));
                end
                k++;
            end
        end
    endtask

    task automatic clear_a();
        a_q.delete();
        a_fd_cnt = 0;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_ready"}, 72'(a_ready), 72'd0);
        check({tag, "_busy"}, 72'(a_busy), 72'd0);
    endtask

    initial begin
        rstN = 1'b0;
        set_in(1'b0, 1'b0, 8'd0, 1'b0);
        set_in(1'b1, 1'b0, 8'd0, 1'b0);
        repeat (2) tick();
        rstN = 1'b1;

        check("rst_win", a_win, 72'd0);
        check("rst_wv", 72'(a_wv), 72'd0);
        check("rst_fd", 72'(a_fd), 72'd0);
        check_idle_a("rst");
        check("rst_b_ready", 72'(b_ready), 72'd0);

        // T1: continuous ramp
        clear_a();
        start_frame(1'b0);
        check("t1_busy_after_start", 72'(a_busy), 72'd1);
        feed(1'b0, 0, 1'b0, 20, -1, 1'b0);
        repeat (3) tick();
        check("t1_nwin", 72'(a_q.size()), 72'd6);
        verify(1'b0, 5, 4, 0, 0);
        check("t1_first", (a_q.size() > 0) ? a_q[0] : 72'd0,
              {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0});
        check("t1_last", (a_q.size() > 5) ? a_q[5] : 72'd0,
              {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9, 8'd8, 8'd7});
        check("t1_fd_cnt", 72'(a_fd_cnt), 72'd1);
        check_idle_a("t1_end");

        // T2: valid toggling
        clear_a();
        start_frame(1'b0);
        feed(1'b0, 0, 1'b1, 20, -1, 1'b0);
        repeat (3) tick();
        check("t2_nwin", 72'(a_q.size()), 72'd6);
        verify(1'b0, 5, 4, 0, 0);
        check("t2_fd_cnt", 72'(a_fd_cnt), 72'd1);

        // T3: start during RUN is ignored
        clear_a();
        start_frame(1'b0);
        feed(1'b0, 0, 1'b0, 20, 15, 1'b0);
        repeat (3) tick();
        check("t3_nwin", 72'(a_q.size()), 72'd6);
        verify(1'b0, 5, 4, 0, 0);
        check("t3_fd_cnt", 72'(a_fd_cnt), 72'd1);
        check_idle_a("t3_end");

        // T4: reset mid-frame, then a full frame
        clear_a();
        start_frame(1'b0);
        feed(1'b0, 0, 1'b0, 12, -1, 1'b0);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        check("t4_rst_win", a_win, 72'd0);
        check("t4_rst_wv", 72'(a_wv), 72'd0);
        check_idle_a("t4_rst");
        repeat (2) tick();
        check("t4_abort_fd", 72'(a_fd_cnt), 72'd0);
        check("t4_abort_nwin", 72'(a_q.size()), 72'd0);
        start_frame(1'b0);
        feed(1'b0, 0, 1'b0, 20, -1, 1'b0);
        repeat (3) tick();
        check("t4_nwin", 72'(a_q.size()), 72'd6);
        verify(1'b0, 5, 4, 0, 0);
        check("t4_fd_cnt", 72'(a_fd_cnt), 72'd1);

        // T5: back-to-back frames, second frame uses different data
        clear_a();
        start_frame(1'b0);
        feed(1'b0, 0, 1'b0, 20, -1, 1'b1);
        check("t5_busy_second", 72'(a_busy), 72'd1);
        feed(1'b0, 100, 1'b0, 20, -1, 1'b0);
        repeat (3) tick();
        check("t5_nwin", 72'(a_q.size()), 72'd12);
        verify(1'b0, 5, 4, 0, 0);
        verify(1'b0, 5, 4, 100, 6);
        check("t5_fd_cnt", 72'(a_fd_cnt), 72'd2);
        check_idle_a("t5_end");

        // T6: minimum 3x3 frame
        start_frame(1'b1);
        feed(1'b1, 1, 1'b0, 9, -1, 1'b0);
        repeat (3) tick();
        check("t6_nwin", 72'(b_q.size()), 72'd1);
        check("t6_win", (b_q.size() > 0) ? b_q[0] : 72'd0,
              {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        check("t6_fd_cnt", 72'(b_fd_cnt), 72'd1);
        check("t6_ready", 72'(b_ready), 72'd0);
        check("t6_busy", 72'(b_busy), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
